// File: rtl/rv32_bus_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and data load/store.
// Optional round-robin fairness via RV32_BUS_ARB_FAIR_EN; otherwise data has strict priority.
module rv32_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_read_in,
   input  logic [31:0] instr_address_in,
   output logic [31:0] instr_read_value_out,
   output logic        instr_ready_out,
   input  logic        data_read_in,
   input  logic        data_write_in,
   input  logic [31:0] data_address_in,
   input  logic [31:0] data_write_value_in,
   input  logic [3:0]  data_write_mask_in,
   output logic [31:0] data_read_value_out,
   output logic        data_ready_out,
   output logic        bus_valid_out,
   output logic        bus_write_out,
   output logic [31:0] bus_address_out,
   output logic [31:0] bus_write_value_out,
   output logic [3:0]  bus_write_mask_out,
   input  logic [31:0] bus_read_value_in,
   input  logic        bus_ready_in,
   output logic        bus_error_out
);

   localparam int unsigned WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, INSTR, DATA} state_e;

   state_e            state_q, state_d;
   logic              bus_valid_q, bus_valid_d;
   logic              bus_write_q, bus_write_d;
   logic [31:0]       bus_address_q, bus_address_d;
   logic [31:0]       bus_write_value_q, bus_write_value_d;
   logic [3:0]        bus_write_mask_q, bus_write_mask_d;
   logic [WD_W-1:0]   wd_q, wd_d;
`ifdef RV32_BUS_ARB_FAIR_EN
   logic              last_data_q, last_data_d;
`endif

   logic busy_c, timeout_c, done_c, data_req_c, grant_data_c;

   // Completion, watchdog and grant decisions
   always_comb begin
      busy_c     = (state_q != IDLE);
      timeout_c  = (TIMEOUT_CYCLES != 0) && busy_c && !bus_ready_in &&
                   (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
      done_c     = busy_c && (bus_ready_in || timeout_c) && !reset;
      data_req_c = data_read_in | data_write_in;
`ifdef RV32_BUS_ARB_FAIR_EN
      grant_data_c = data_req_c && !(instr_read_in && last_data_q);
`else
      grant_data_c = data_req_c;
`endif
   end

   // Ready, read data and error are same-cycle responses to bus_ready_in / timeout
   always_comb begin
      instr_ready_out      = done_c && (state_q == INSTR);
      data_ready_out       = done_c && (state_q == DATA);
      bus_error_out        = timeout_c && !reset;
      instr_read_value_out = (instr_ready_out && !timeout_c) ? bus_read_value_in : 32'd0;
      data_read_value_out  = (data_ready_out && !timeout_c) ? bus_read_value_in : 32'd0;
   end

   // Next-state and bus register update
   always_comb begin
      state_d           = state_q;
      bus_valid_d       = bus_valid_q;
      bus_write_d       = bus_write_q;
      bus_address_d     = bus_address_q;
      bus_write_value_d = bus_write_value_q;
      bus_write_mask_d  = bus_write_mask_q;
      wd_d              = wd_q;
`ifdef RV32_BUS_ARB_FAIR_EN
      last_data_d       = last_data_q;
`endif
      case (state_q)
         IDLE: begin
            wd_d = '0;
            if (grant_data_c) begin
               state_d           = DATA;
               bus_valid_d       = 1'b1;
               bus_write_d       = data_write_in;
               bus_address_d     = data_address_in;
               bus_write_value_d = data_write_in ? data_write_value_in : 32'd0;
               bus_write_mask_d  = data_write_in ? data_write_mask_in : 4'd0;
`ifdef RV32_BUS_ARB_FAIR_EN
               last_data_d       = 1'b1;
`endif
            end else if (instr_read_in) begin
               state_d           = INSTR;
               bus_valid_d       = 1'b1;
               bus_write_d       = 1'b0;
               bus_address_d     = instr_address_in;
               bus_write_value_d = 32'd0;
               bus_write_mask_d  = 4'd0;
`ifdef RV32_BUS_ARB_FAIR_EN
               last_data_d       = 1'b0;
`endif
            end
         end
         INSTR, DATA: begin
            if (bus_ready_in || timeout_c) begin
               state_d           = IDLE;
               bus_valid_d       = 1'b0;
               bus_write_d       = 1'b0;
               bus_address_d     = 32'd0;
               bus_write_value_d = 32'd0;
               bus_write_mask_d  = 4'd0;
               wd_d              = '0;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q           <= IDLE;
         bus_valid_q       <= 1'b0;
         bus_write_q       <= 1'b0;
         bus_address_q     <= 32'd0;
         bus_write_value_q <= 32'd0;
         bus_write_mask_q  <= 4'd0;
         wd_q              <= '0;
`ifdef RV32_BUS_ARB_FAIR_EN
         last_data_q       <= 1'b0;
`endif
      end else begin
         state_q           <= state_d;
         bus_valid_q       <= bus_valid_d;
         bus_write_q       <= bus_write_d;
         bus_address_q     <= bus_address_d;
         bus_write_value_q <= bus_write_value_d;
         bus_write_mask_q  <= bus_write_mask_d;
         wd_q              <= wd_d;
`ifdef RV32_BUS_ARB_FAIR_EN
         last_data_q       <= last_data_d;
`endif
      end
   end

   assign bus_valid_out       = bus_valid_q;
   assign bus_write_out       = bus_write_q;
   assign bus_address_out     = bus_address_q;
   assign bus_write_value_out = bus_write_value_q;
   assign bus_write_mask_out  = bus_write_mask_q;

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Directed self-checking bench for rv32_bus_arbiter (watchdog set to 4 cycles).
module tb_rv32_bus_arbiter;

   logic        clk;
   logic        reset;
   logic        instr_read_in;
   logic [31:0] instr_address_in;
   logic [31:0] instr_read_value_out;
   logic        instr_ready_out;
   logic        data_read_in;
   logic        data_write_in;
   logic [31:0] data_address_in;
   logic [31:0] data_write_value_in;
   logic [3:0]  data_write_mask_in;
   logic [31:0] data_read_value_out;
   logic        data_ready_out;
   logic        bus_valid_out;
   logic        bus_write_out;
   logic [31:0] bus_address_out;
   logic [31:0] bus_write_value_out;
   logic [3:0]  bus_write_mask_out;
   logic [31:0] bus_read_value_in;
   logic        bus_ready_in;
   logic        bus_error_out;

   int tests = 0;
   int fails = 0;

   rv32_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk                  (clk),
      .reset                (reset),
      .instr_read_in        (instr_read_in),
      .instr_address_in     (instr_address_in),
      .instr_read_value_out (instr_read_value_out),
      .instr_ready_out      (instr_ready_out),
      .data_read_in         (data_read_in),
      .data_write_in        (data_write_in),
      .data_address_in      (data_address_in),
      .data_write_value_in  (data_write_value_in),
      .data_write_mask_in   (data_write_mask_in),
      .data_read_value_out  (data_read_value_out),
      .data_ready_out       (data_ready_out),
      .bus_valid_out        (bus_valid_out),
      .bus_write_out        (bus_write_out),
      .bus_address_out      (bus_address_out),
      .bus_write_value_out  (bus_write_value_out),
      .bus_write_mask_out   (bus_write_mask_out),
      .bus_read_value_in    (bus_read_value_in),
      .bus_ready_in         (bus_ready_in),
      .bus_error_out        (bus_error_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      instr_read_in = 1'b1; instr_address_in = 32'h0000_0010;
      data_write_in = 1'b1; data_address_in = 32'h0000_0020;
      data_write_value_in = 32'h1234_5678; data_write_mask_in = 4'hF;
      for (int i = 0; i < 3; i++) begin
         cyc(); #1;
         tests++; if (bus_valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus_valid_out); end
         tests++; if (bus_address_out !== 32'd0) begin fails++; $display("FAIL reset_addr: got %h want 0", bus_address_out); end
         tests++; if ({instr_ready_out, data_ready_out, bus_error_out, bus_write_out} !== 4'b0) begin
            fails++; $display("FAIL reset_flags: got %b want 0000", {instr_ready_out, data_ready_out, bus_error_out, bus_write_out});
         end
      end
      reset = 1'b0;
      instr_read_in = 1'b0; data_write_in = 1'b0;
      cyc(); #1;
      tests++; if (bus_valid_out !== 1'b0) begin fails++; $display("FAIL post_reset_valid: got %b want 0", bus_valid_out); end
   endtask

   task automatic test_instr_read();
      instr_read_in = 1'b1; instr_address_in = 32'h0000_0040;
      bus_read_value_in = 32'h0000_0013;
      cyc(); #1;
      tests++; if (bus_valid_out !== 1'b1) begin fails++; $display("FAIL ird_valid: got %b want 1", bus_valid_out); end
      tests++; if (bus_address_out !== 32'h40) begin fails++; $display("FAIL ird_addr: got %h want 00000040", bus_address_out); end
      tests++; if ({bus_write_out, bus_write_mask_out} !== 5'b0) begin fails++; $display("FAIL ird_rdmask: got %b want 00000", {bus_write_out, bus_write_mask_out}); end
      tests++; if (instr_read_value_out !== 32'd0) begin fails++; $display("FAIL ird_val_idle: got %h want 0", instr_read_value_out); end
      cyc(); #1;
      tests++; if (instr_ready_out !== 1'b0) begin fails++; $display("FAIL ird_early_ready: got %b want 0", instr_ready_out); end
      cyc();
      bus_ready_in = 1'b1; #1;
      tests++; if (instr_ready_out !== 1'b1) begin fails++; $display("FAIL ird_ready: got %b want 1", instr_ready_out); end
      tests++; if (instr_read_value_out !== 32'h13) begin fails++; $display("FAIL ird_value: got %h want 00000013", instr_read_value_out); end
      tests++; if (data_ready_out !== 1'b0) begin fails++; $display("FAIL ird_data_ready: got %b want 0", data_ready_out); end
      cyc();
      bus_ready_in = 1'b0; instr_read_in = 1'b0; #1;
      tests++; if ({bus_valid_out, instr_ready_out} !== 2'b00) begin fails++; $display("FAIL ird_done: got %b want 00", {bus_valid_out, instr_ready_out}); end
   endtask

   task automatic test_store();
      data_write_in = 1'b1; data_address_in = 32'h0000_0100;
      data_write_value_in = 32'hDEAD_BEEF; data_write_mask_in = 4'b0011;
      cyc(); #1;
      tests++; if ({bus_valid_out, bus_write_out} !== 2'b11) begin fails++; $display("FAIL st_valid_write: got %b want 11", {bus_valid_out, bus_write_out}); end
      tests++; if (bus_address_out !== 32'h100) begin fails++; $display("FAIL st_addr: got %h want 00000100", bus_address_out); end
      tests++; if (bus_write_value_out !== 32'hDEAD_BEEF) begin fails++; $display("FAIL st_wdata: got %h want deadbeef", bus_write_value_out); end
      tests++; if (bus_write_mask_out !== 4'b0011) begin fails++; $display("FAIL st_mask: got %b want 0011", bus_write_mask_out); end
      data_address_in = 32'h0000_0200; data_write_value_in = 32'd0; data_write_mask_in = 4'hF;
      cyc(); #1;
      tests++; if ({bus_address_out, bus_write_value_out, bus_write_mask_out} !== {32'h100, 32'hDEAD_BEEF, 4'b0011}) begin
         fails++; $display("FAIL st_hold: got %h %h %b want 00000100 deadbeef 0011", bus_address_out, bus_write_value_out, bus_write_mask_out);
      end
      tests++; if (data_ready_out !== 1'b0) begin fails++; $display("FAIL st_early_ready: got %b want 0", data_ready_out); end
      cyc();
      bus_ready_in = 1'b1; bus_read_value_in = 32'h55; #1;
      tests++; if ({data_ready_out, instr_ready_out} !== 2'b10) begin fails++; $display("FAIL st_ready: got %b want 10", {data_ready_out, instr_ready_out}); end
      cyc();
      bus_ready_in = 1'b0; data_write_in = 1'b0; #1;
      tests++; if ({bus_valid_out, data_ready_out} !== 2'b00) begin fails++; $display("FAIL st_done: got %b want 00", {bus_valid_out, data_ready_out}); end
   endtask

   task automatic test_arbitration();
      logic [31:0] exp_addr;
      logic        exp_data;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      instr_read_in = 1'b1; instr_address_in = 32'h0000_1000;
      data_read_in  = 1'b1; data_address_in  = 32'h0000_2000;
      for (int i = 0; i < 4; i++) begin
`ifdef RV32_BUS_ARB_FAIR_EN
         exp_data = (i % 2 == 0);
`else
         exp_data = 1'b1;
`endif
         exp_addr = exp_data ? 32'h2000 : 32'h1000;
         cyc(); #1;
         tests++; if (bus_address_out !== exp_addr) begin fails++; $display("FAIL arb_grant%0d: got %h want %h", i, bus_address_out, exp_addr); end
         cyc();
         bus_ready_in = 1'b1; bus_read_value_in = 32'hA0 + 32'(i); #1;
         tests++; if ({data_ready_out, instr_ready_out} !== {exp_data, ~exp_data}) begin
            fails++; $display("FAIL arb_ready%0d: got %b want %b", i, {data_ready_out, instr_ready_out}, {exp_data, ~exp_data});
         end
         cyc();
         bus_ready_in = 1'b0; #1;
         tests++; if (bus_valid_out !== 1'b0) begin fails++; $display("FAIL arb_bubble%0d: got %b want 0", i, bus_valid_out); end
      end
      instr_read_in = 1'b0; data_read_in = 1'b0;
      cyc();
   endtask

   task automatic test_watchdog();
      data_read_in = 1'b1; data_address_in = 32'h0000_0300;
      bus_read_value_in = 32'hFFFF_FFFF;
      cyc();
      for (int k = 1; k <= 3; k++) begin
         #1;
         tests++; if ({bus_error_out, data_ready_out} !== 2'b00) begin fails++; $display("FAIL wd_wait%0d: got %b want 00", k, {bus_error_out, data_ready_out}); end
         cyc();
      end
      #1;
      tests++; if ({bus_error_out, data_ready_out} !== 2'b11) begin fails++; $display("FAIL wd_abort: got %b want 11", {bus_error_out, data_ready_out}); end
      tests++; if (data_read_value_out !== 32'd0) begin fails++; $display("FAIL wd_value: got %h want 0", data_read_value_out); end
      cyc();
      data_read_in = 1'b0; #1;
      tests++; if ({bus_valid_out, bus_error_out, data_ready_out} !== 3'b000) begin
         fails++; $display("FAIL wd_idle: got %b want 000", {bus_valid_out, bus_error_out, data_ready_out});
      end
      // bus_ready_in on the timeout cycle completes normally
      data_read_in = 1'b1; data_address_in = 32'h0000_0304;
      cyc(); cyc(); cyc(); cyc();
      bus_ready_in = 1'b1; bus_read_value_in = 32'h0000_ABCD; #1;
      tests++; if ({bus_error_out, data_ready_out} !== 2'b01) begin fails++; $display("FAIL wd_race_flags: got %b want 01", {bus_error_out, data_ready_out}); end
      tests++; if (data_read_value_out !== 32'h0000_ABCD) begin fails++; $display("FAIL wd_race_value: got %h want 0000abcd", data_read_value_out); end
      cyc();
      bus_ready_in = 1'b0; data_read_in = 1'b0; #1;
      tests++; if (bus_valid_out !== 1'b0) begin fails++; $display("FAIL wd_race_done: got %b want 0", bus_valid_out); end
   endtask

   task automatic test_reset_mid();
      instr_read_in = 1'b1; instr_address_in = 32'h0000_0080;
      bus_read_value_in = 32'h77;
      cyc(); #1;
      tests++; if (bus_valid_out !== 1'b1) begin fails++; $display("FAIL rm_valid: got %b want 1", bus_valid_out); end
      cyc();
      reset = 1'b1; bus_ready_in = 1'b1; #1;
      tests++; if ({instr_ready_out, bus_error_out} !== 2'b00) begin fails++; $display("FAIL rm_no_ready: got %b want 00", {instr_ready_out, bus_error_out}); end
      tests++; if (instr_read_value_out !== 32'd0) begin fails++; $display("FAIL rm_value: got %h want 0", instr_read_value_out); end
      cyc();
      reset = 1'b0; bus_ready_in = 1'b0; instr_read_in = 1'b0; #1;
      tests++; if (bus_valid_out !== 1'b0) begin fails++; $display("FAIL rm_valid_clear: got %b want 0", bus_valid_out); end
      cyc(); #1;
      tests++; if ({bus_valid_out, instr_ready_out} !== 2'b00) begin fails++; $display("FAIL rm_idle: got %b want 00", {bus_valid_out, instr_ready_out}); end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, want finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      reset = 1'b1;
      instr_read_in = 1'b0; instr_address_in = 32'd0;
      data_read_in = 1'b0; data_write_in = 1'b0; data_address_in = 32'd0;
      data_write_value_in = 32'd0; data_write_mask_in = 4'd0;
      bus_read_value_in = 32'd0; bus_ready_in = 1'b0;
      test_reset();
      test_instr_read();
      test_store();
      test_arbitration();
      test_watchdog();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
